hexa_output_scheduler: RTL

//  Per-output-port scheduler for the hexa 5-port router (x+,x-,y+,y-,pe). Arbitrates

---
 rtl/hexa_pkg.sv | 24 ++
 rtl/hexa_output_scheduler_rr_arbiter.sv | 32 +++
 rtl/hexa_output_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/hexa_pkg.sv
// Shared definitions for the hexa 5-port router: port offsets, scheduler states and
// a constant-width helper.
package hexa_pkg;

    localparam int NUM_PORTS = 5;
    localparam int XPOS      = 0;
    localparam int XNEG      = 1;
    localparam int YPOS      = 2;
    localparam int YNEG      = 3;
    localparam int PE        = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/hexa_output_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// PORTS-1 -> 0. Returns one-hot grant, binary index and an any-request flag.
module rr_arbiter #(
    parameter int PORTS = 5,
    parameter int IDX_W = 3
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [PORTS-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int p;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int off = 0; off < PORTS; off++) begin
            p = int'(ptr) + off;
            if (p >= PORTS) p = p - PORTS;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/hexa_output_scheduler.sv
// Per-output-port wormhole scheduler: round-robin owner selection, ownership held
// from head to tail flit, transfers gated by downstream credits.
module hexa_output_scheduler
    import hexa_pkg::*;
#(
    parameter int PORTS        = NUM_PORTS,
    parameter int PORT_ID      = XPOS,
    parameter int BUFFER_DEPTH = 4,
    parameter int CRT_W        = clog2(BUFFER_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic [PORTS-1:0] tail,
    input  logic             credit_in,
    output logic [PORTS-1:0] grant,
    output logic [2:0]       xbar_sel,
    output logic             fire,
    output logic [CRT_W-1:0] credit_count,
    output logic             credit_ovf
);

    localparam logic [PORTS-1:0] PORT_MASK = ~(PORTS'(1) << PORT_ID);
    localparam logic [CRT_W-1:0] CRT_MAX   = CRT_W'(BUFFER_DEPTH);
    localparam logic [2:0]       LAST_IDX  = 3'(PORTS - 1);

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_d;
    logic [2:0]       sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [PORTS-1:0] eff_req;
    logic [PORTS-1:0] arb_gnt;
    logic [2:0]       arb_idx;
    logic             arb_any;
    logic             credit_ok;

    assign eff_req   = req & PORT_MASK;
    assign credit_ok = (credit_count != '0);
    assign fire      = !rst && (state_q == ACTIVE) && req[xbar_sel] && credit_ok;

    rr_arbiter #(
        .PORTS(PORTS),
        .IDX_W(3)
    ) u_arb (
        .req(eff_req),
        .ptr(ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        sel_d   = xbar_sel;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_any && credit_ok) begin
                    state_d = ACTIVE;
                    grant_d = arb_gnt;
                    sel_d   = arb_idx;
                end
            end
            ACTIVE: begin
                // Other requesters stay locked out until the owner's tail leaves.
                if (fire && tail[xbar_sel]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    ptr_d   = (xbar_sel == LAST_IDX) ? 3'd0 : xbar_sel + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant    <= '0;
            xbar_sel <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            xbar_sel <= sel_d;
            ptr_q    <= ptr_d;
        end
    end

    // A simultaneous fire and credit return cancel; the counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_count <= CRT_MAX;
            credit_ovf   <= 1'b0;
        end else begin
            case ({fire, credit_in})
                2'b10: credit_count <= credit_count - CRT_W'(1);
                2'b01: begin
                    if (credit_count == CRT_MAX) credit_ovf <= 1'b1;
                    else                         credit_count <= credit_count + CRT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
